alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Registered, handshaked successor to the combinational ALU control decoder. Accepts `{alu_op, alu_function}` from the control/decode stage, decodes it to a 4-bit ALU operation code, and presents it on a valid/ready output toward the ALU/MDU datapath. Single-cycle ops occupy one output beat. MULT/DIV are sequenced as `MD_ITER` stepped beats, so the iterative multiply/divide unit needs no local control. Sits between the main control unit and the ALU/MDU in the pipelined core.

## Interface
- `OP_W`, 3, ALUOp width; must be ≥3.
- `FUNCT_W`, 6, function-field width; must be ≥6.
- `OPER_W`, 4, output operation width; must be ≥4. Codes are zero-extended.
- `MD_ITER`, 32, beats per MULT/DIV; must be ≥2. `CNT_W = $clog2(MD_ITER)` is a derived localparam.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `flush` in 1: synchronous abort of the op in flight.
- `in_valid` in 1: request present.
- `in_ready` out 1: request accepted when `in_valid && in_ready`.
- `alu_op` in `OP_W`: ALUOp from the control unit.
- `alu_function` in `FUNCT_W`: instruction funct field.
- `out_valid` out 1: operation beat present.
- `out_ready` in 1: downstream consumes the beat.
- `alu_operation` out `OPER_W`: decoded operation code.
- `out_step` out `CNT_W`: beat index within a MULT/DIV; 0 for single-beat ops.
- `out_last` out 1: final beat of the operation.
- `out_illegal` out 1: undecodable request.

## Operation
- Decode applies when `alu_op` is 111 (R-type), keyed on funct:
  - 100100 → AND 0000; 100101 → OR 0001; 100111 → NOR 0010.
  - 100000 → ADD 0011; 100010 → SUB 0100.
  - 000000 → SLL 0110; 000010 → SRL 0111.
  - 011000 → MULT 1010; 011010 → DIV 1011.
  - 010000 → MFHI 1100; 010010 → MFLO 1101; 001000 JR → NOP 1110.
- Decode for other `alu_op` values (funct ignored):
  - 100 ADDI → 0011; 101 ORI → 0001; 110 LUI → 0101.
  - 000 BEQ → 1000; 001 BNE → 1001.
  - 011 LW → 0011; 010 SW → 0011.
- Any other code, or nonzero bits of `alu_op`/`alu_function` above bit 2/5, is illegal.
  - Output is 1111 with `out_illegal=1`, as a single beat.
- FSM states: IDLE, SINGLE, ITER.
  - IDLE: `in_ready=1`, `out_valid=0`. On accept, decode is registered. MULT/DIV → ITER with count 0; everything else → SINGLE.
  - SINGLE: `out_valid=1`, `out_last=1`, `out_step=0`. On `out_ready`: accept a new request if `in_valid` (next state from its decode), else → IDLE.
  - ITER: `out_valid=1`, `out_step=count`, `out_last=(count==MD_ITER-1)`. Each `out_ready` cycle increments count. On the last beat with `out_ready`, behave as SINGLE completion. Without `out_ready`, all outputs hold.
- `in_ready` = (state==IDLE) || (`out_valid && out_last && out_ready`), forced to 0 while `reset` or `flush` is high.
- `flush`: next edge → IDLE, count 0, outputs at reset values. Any request presented that cycle is not accepted.
- `reset` has priority over `flush`. Mid-ITER reset aborts without a last beat.

## Timing
- Reset values:
  - `out_valid=0`, `alu_operation=0`, `out_step=0`, `out_last=0`, `out_illegal=0`.
  - State IDLE, count 0.
- Latency: accept at edge N → `out_valid=1` after edge N (visible in cycle N+1). All outputs are registered; no input-to-output combinational path except `in_ready` from `out_ready`.
- Throughput, single-beat ops: one per cycle with `in_valid` and `out_ready` held high.
- MULT/DIV with `out_ready` held high: `MD_ITER` beats, steps 0..`MD_ITER-1`, last beat `MD_ITER` cycles after accept. Back-to-back MULTs are gapless.
- Output stability: `alu_operation`, `out_step`, `out_last`, `out_illegal` hold while `out_valid && !out_ready`.
- Count wrap: count never exceeds `MD_ITER-1`. It resets to 0 on every new accept.

## Structure
- Shared package `alu_ctrl_pkg`:
  - ALUOp codes, funct codes, 4-bit operation codes including new 1010–1111, and the state enum.
  - To be shared with the ALU and MDU.
- Sub-module `alu_op_decode`: purely combinational.
  - Inputs: `{alu_op, alu_function}`.
  - Outputs: `{operation, is_multi, illegal}`.
  - The sequencer registers its outputs.

## Test plan
- Reset held 2 cycles then released, `in_valid=0` → all outputs 0, `in_ready=1`.
- ADD (111/100000), SUB, ORI (101), LW (011) back-to-back with `out_ready=1` → `alu_operation` 0011, 0100, 0001, 0011 on consecutive cycles, each with `out_last=1`.
- MULT (111/011000) with `MD_ITER=4`, `out_ready=1` → 4 beats of 1010, `out_step` 0,1,2,3, `out_last` only on step 3. `in_ready=1` on the step-3 cycle only.
- Same MULT, `out_ready` low 3 cycles at step 1 → step 1 held stable, then continues 2,3. Total 7 cycles.
- `alu_op`=111, funct 111111 → one beat of 1111 with `out_illegal=1`. JR → 1110 with `out_illegal=0`.
- `flush` at step 2 of DIV → next cycle `out_valid=0`, IDLE. Following ADDI yields 0011 at step 0. Same scenario with `reset` instead of `flush` gives identical behaviour.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control definitions: ALUOp and funct encodings, operation codes
// and the sequencer state type, for use by the control path, ALU and MDU.
package alu_ctrl_pkg;

   localparam logic [2:0] ALUOP_BEQ   = 3'b000;
   localparam logic [2:0] ALUOP_BNE   = 3'b001;
   localparam logic [2:0] ALUOP_SW    = 3'b010;
   localparam logic [2:0] ALUOP_LW    = 3'b011;
   localparam logic [2:0] ALUOP_ADDI  = 3'b100;
   localparam logic [2:0] ALUOP_ORI   = 3'b101;
   localparam logic [2:0] ALUOP_LUI   = 3'b110;
   localparam logic [2:0] ALUOP_RTYPE = 3'b111;

   localparam logic [5:0] FUNCT_SLL  = 6'b000000;
   localparam logic [5:0] FUNCT_SRL  = 6'b000010;
   localparam logic [5:0] FUNCT_JR   = 6'b001000;
   localparam logic [5:0] FUNCT_MFHI = 6'b010000;
   localparam logic [5:0] FUNCT_MFLO = 6'b010010;
   localparam logic [5:0] FUNCT_MULT = 6'b011000;
   localparam logic [5:0] FUNCT_DIV  = 6'b011010;
   localparam logic [5:0] FUNCT_ADD  = 6'b100000;
   localparam logic [5:0] FUNCT_SUB  = 6'b100010;
   localparam logic [5:0] FUNCT_AND  = 6'b100100;
   localparam logic [5:0] FUNCT_OR   = 6'b100101;
   localparam logic [5:0] FUNCT_NOR  = 6'b100111;

   localparam logic [3:0] OPER_AND     = 4'b0000;
   localparam logic [3:0] OPER_OR      = 4'b0001;
   localparam logic [3:0] OPER_NOR     = 4'b0010;
   localparam logic [3:0] OPER_ADD     = 4'b0011;
   localparam logic [3:0] OPER_SUB     = 4'b0100;
   localparam logic [3:0] OPER_LUI     = 4'b0101;
   localparam logic [3:0] OPER_SLL     = 4'b0110;
   localparam logic [3:0] OPER_SRL     = 4'b0111;
   localparam logic [3:0] OPER_BEQ     = 4'b1000;
   localparam logic [3:0] OPER_BNE     = 4'b1001;
   localparam logic [3:0] OPER_MULT    = 4'b1010;
   localparam logic [3:0] OPER_DIV     = 4'b1011;
   localparam logic [3:0] OPER_MFHI    = 4'b1100;
   localparam logic [3:0] OPER_MFLO    = 4'b1101;
   localparam logic [3:0] OPER_NOP     = 4'b1110;
   localparam logic [3:0] OPER_ILLEGAL = 4'b1111;

   typedef enum logic [1:0] {
      IDLE,
      SINGLE,
      ITER
   } seq_state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of {alu_op, alu_function} into an operation code,
// a multi-beat flag for MULT/DIV and an illegal-request flag.
module alu_op_decode
   import alu_ctrl_pkg::*;
#(
   parameter int OP_W    = 3,
   parameter int FUNCT_W = 6,
   parameter int OPER_W  = 4
) (
   input  logic [OP_W-1:0]    alu_op,
   input  logic [FUNCT_W-1:0] alu_function,
   output logic [OPER_W-1:0]  operation,
   output logic               is_multi,
   output logic               illegal
);

   logic [3:0] code;
   logic       bad;
   logic       high_bits;

   assign high_bits = ((alu_op >> 3) != '0) || ((alu_function >> 6) != '0);

   // Only R-type looks at funct; an illegal request never becomes multi-beat.
   always_comb begin
      code     = OPER_ILLEGAL;
      is_multi = 1'b0;
      bad      = 1'b0;
      case (alu_op[2:0])
         ALUOP_RTYPE: begin
            case (alu_function[5:0])
               FUNCT_AND:  code = OPER_AND;
               FUNCT_OR:   code = OPER_OR;
               FUNCT_NOR:  code = OPER_NOR;
               FUNCT_ADD:  code = OPER_ADD;
               FUNCT_SUB:  code = OPER_SUB;
               FUNCT_SLL:  code = OPER_SLL;
               FUNCT_SRL:  code = OPER_SRL;
               FUNCT_MULT: begin code = OPER_MULT; is_multi = 1'b1; end
               FUNCT_DIV:  begin code = OPER_DIV;  is_multi = 1'b1; end
               FUNCT_MFHI: code = OPER_MFHI;
               FUNCT_MFLO: code = OPER_MFLO;
               FUNCT_JR:   code = OPER_NOP;
               default:    bad  = 1'b1;
            endcase
         end
         ALUOP_ADDI: code = OPER_ADD;
         ALUOP_ORI:  code = OPER_OR;
         ALUOP_LUI:  code = OPER_LUI;
         ALUOP_BEQ:  code = OPER_BEQ;
         ALUOP_BNE:  code = OPER_BNE;
         ALUOP_LW:   code = OPER_ADD;
         ALUOP_SW:   code = OPER_ADD;
         default:    bad  = 1'b1;
      endcase
      if (bad || high_bits) begin
         code     = OPER_ILLEGAL;
         is_multi = 1'b0;
      end
   end

   assign operation = OPER_W'(code);
   assign illegal   = bad || high_bits;

endmodule

// File: rtl/alu_op_sequencer.sv
// Registered valid/ready front end for the ALU/MDU: single-cycle ops emit one
// beat, MULT/DIV emit MD_ITER stepped beats so the MDU needs no own control.
module alu_op_sequencer
   import alu_ctrl_pkg::*;
#(
   parameter int    OP_W    = 3,
   parameter int    FUNCT_W = 6,
   parameter int    OPER_W  = 4,
   parameter int    MD_ITER = 32,
   localparam int   CNT_W   = $clog2(MD_ITER)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [OP_W-1:0]    alu_op,
   input  logic [FUNCT_W-1:0] alu_function,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [OPER_W-1:0]  alu_operation,
   output logic [CNT_W-1:0]   out_step,
   output logic               out_last,
   output logic               out_illegal
);

   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MD_ITER - 1);

   seq_state_t        state_q, state_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [OPER_W-1:0] oper_q, oper_d;
   logic              illegal_q, illegal_d;

   logic [OPER_W-1:0] dec_oper;
   logic              dec_multi;
   logic              dec_illegal;
   logic              at_last;
   logic              beat_done;
   logic              accept;

   alu_op_decode #(
      .OP_W    (OP_W),
      .FUNCT_W (FUNCT_W),
      .OPER_W  (OPER_W)
   ) u_decode (
      .alu_op       (alu_op),
      .alu_function (alu_function),
      .operation    (dec_oper),
      .is_multi     (dec_multi),
      .illegal      (dec_illegal)
   );

   assign at_last   = (state_q == SINGLE) || ((state_q == ITER) && (count_q == LAST_STEP));
   assign out_valid = (state_q != IDLE);
   assign beat_done = out_valid && at_last && out_ready;
   assign in_ready  = !reset && !flush && ((state_q == IDLE) || beat_done);
   assign accept    = in_valid && in_ready;

   // A completing beat drops back to IDLE unless a new request is taken in
   // the same cycle, which keeps single ops and back-to-back MULTs gapless.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      oper_d    = oper_q;
      illegal_d = illegal_q;
      case (state_q)
         SINGLE: begin
            if (out_ready) begin
               state_d   = IDLE;
               oper_d    = '0;
               illegal_d = 1'b0;
            end
         end
         ITER: begin
            if (out_ready) begin
               if (count_q == LAST_STEP) begin
                  state_d   = IDLE;
                  count_d   = '0;
                  oper_d    = '0;
                  illegal_d = 1'b0;
               end else begin
                  count_d = count_q + 1'b1;
               end
            end
         end
         default: ;
      endcase
      if (accept) begin
         state_d   = dec_multi ? ITER : SINGLE;
         count_d   = '0;
         oper_d    = dec_oper;
         illegal_d = dec_illegal;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         state_q   <= IDLE;
         count_q   <= '0;
         oper_q    <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         oper_q    <= oper_d;
         illegal_q <= illegal_d;
      end
   end

   assign alu_operation = oper_q;
   assign out_step      = count_q;
   assign out_last      = at_last;
   assign out_illegal   = illegal_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer with MD_ITER=4.
module tb_alu_op_sequencer;

   logic       clk;
   logic       reset;
   logic       flush;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] alu_op;
   logic [5:0] alu_function;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] alu_operation;
   logic [1:0] out_step;
   logic       out_last;
   logic       out_illegal;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [2:0] op;
      logic [5:0] fn;
      logic [3:0] oper;
      logic       ill;
   } vec_t;

   vec_t vecs[$];

   alu_op_sequencer #(
      .OP_W    (3),
      .FUNCT_W (6),
      .OPER_W  (4),
      .MD_ITER (4)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .flush         (flush),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .alu_op        (alu_op),
      .alu_function  (alu_function),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .alu_operation (alu_operation),
      .out_step      (out_step),
      .out_last      (out_last),
      .out_illegal   (out_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [5:0] fn,
                                input logic ordy, input logic fl, input logic rst);
      in_valid     = v;
      alu_op       = op;
      alu_function = fn;
      out_ready    = ordy;
      flush        = fl;
      reset        = rst;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, "_valid"}, 32'(out_valid), 32'd0);
      checkOutput({tag, "_oper"}, 32'(alu_operation), 32'd0);
      checkOutput({tag, "_step"}, 32'(out_step), 32'd0);
      checkOutput({tag, "_last"}, 32'(out_last), 32'd0);
      checkOutput({tag, "_ill"}, 32'(out_illegal), 32'd0);
   endtask

   // MULT/DIV with optional stall: stall_cycles of out_ready low while at step 1.
   task automatic runMulti(input logic [5:0] fn, input logic [3:0] code, input int stall_cycles);
      applyStimulus(1'b1, 3'b111, fn, 1'b1, 1'b0, 1'b0);
      #1;
      checkOutput("md_accept_rdy", 32'(in_ready), 32'd1);
      nextCycle();
      for (int s = 0; s < 4; s++) begin
         if (s == 1) begin
            for (int h = 0; h < stall_cycles; h++) begin
               applyStimulus(1'b1, 3'b111, 6'b100000, 1'b0, 1'b0, 1'b0);
               #1;
               checkOutput("md_stall_step", 32'(out_step), 32'd1);
               checkOutput("md_stall_oper", 32'(alu_operation), 32'(code));
               checkOutput("md_stall_last", 32'(out_last), 32'd0);
               checkOutput("md_stall_rdy", 32'(in_ready), 32'd0);
               nextCycle();
            end
         end
         applyStimulus(1'b0, 3'b000, 6'b000000, 1'b1, 1'b0, 1'b0);
         #1;
         checkOutput("md_valid", 32'(out_valid), 32'd1);
         checkOutput("md_oper", 32'(alu_operation), 32'(code));
         checkOutput("md_step", 32'(out_step), 32'(s));
         checkOutput("md_last", 32'(out_last), (s == 3) ? 32'd1 : 32'd0);
         checkOutput("md_in_ready", 32'(in_ready), (s == 3) ? 32'd1 : 32'd0);
         nextCycle();
      end
      checkOutput("md_done_valid", 32'(out_valid), 32'd0);
   endtask

   initial begin
      applyStimulus(1'b0, 3'b000, 6'b000000, 1'b0, 1'b0, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_held_rdy", 32'(in_ready), 32'd0);
      applyStimulus(1'b0, 3'b000, 6'b000000, 1'b0, 1'b0, 1'b0);
      #1;
      checkIdle("rst");
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

      vecs.push_back('{3'b111, 6'b100000, 4'b0011, 1'b0});
      vecs.push_back('{3'b111, 6'b100010, 4'b0100, 1'b0});
      vecs.push_back('{3'b101, 6'b000000, 4'b0001, 1'b0});
      vecs.push_back('{3'b011, 6'b000000, 4'b0011, 1'b0});
      vecs.push_back('{3'b111, 6'b100100, 4'b0000, 1'b0});
      vecs.push_back('{3'b111, 6'b100101, 4'b0001, 1'b0});
      vecs.push_back('{3'b111, 6'b100111, 4'b0010, 1'b0});
      vecs.push_back('{3'b111, 6'b000000, 4'b0110, 1'b0});
      vecs.push_back('{3'b111, 6'b000010, 4'b0111, 1'b0});
      vecs.push_back('{3'b111, 6'b010000, 4'b1100, 1'b0});
      vecs.push_back('{3'b111, 6'b010010, 4'b1101, 1'b0});
      vecs.push_back('{3'b111, 6'b001000, 4'b1110, 1'b0});
      vecs.push_back('{3'b000, 6'b111111, 4'b1000, 1'b0});
      vecs.push_back('{3'b001, 6'b000000, 4'b1001, 1'b0});
      vecs.push_back('{3'b010, 6'b000000, 4'b0011, 1'b0});
      vecs.push_back('{3'b100, 6'b101010, 4'b0011, 1'b0});
      vecs.push_back('{3'b110, 6'b000000, 4'b0101, 1'b0});
      vecs.push_back('{3'b111, 6'b111111, 4'b1111, 1'b1});
      vecs.push_back('{3'b111, 6'b000001, 4'b1111, 1'b1});
      vecs.push_back('{3'b111, 6'b100000, 4'b0011, 1'b0});

      // Back-to-back single-beat stream: each cycle shows the previous request.
      for (int i = 0; i <= vecs.size(); i++) begin
         if (i < vecs.size())
            applyStimulus(1'b1, vecs[i].op, vecs[i].fn, 1'b1, 1'b0, 1'b0);
         else
            applyStimulus(1'b0, 3'b000, 6'b000000, 1'b1, 1'b0, 1'b0);
         #1;
         checkOutput("seq_in_ready", 32'(in_ready), 32'd1);
         if (i > 0) begin
            checkOutput("seq_valid", 32'(out_valid), 32'd1);
            checkOutput("seq_oper", 32'(alu_operation), 32'(vecs[i-1].oper));
            checkOutput("seq_ill", 32'(out_illegal), 32'(vecs[i-1].ill));
            checkOutput("seq_last", 32'(out_last), 32'd1);
            checkOutput("seq_step", 32'(out_step), 32'd0);
         end
         nextCycle();
      end
      checkOutput("seq_drain_valid", 32'(out_valid), 32'd0);

      runMulti(6'b011000, 4'b1010, 0);
      runMulti(6'b011000, 4'b1010, 3);
      runMulti(6'b011010, 4'b1011, 0);

      // Abort DIV at step 2 via flush (k=0) then via reset (k=1).
      for (int k = 0; k < 2; k++) begin
         applyStimulus(1'b1, 3'b111, 6'b011010, 1'b1, 1'b0, 1'b0);
         nextCycle();
         for (int s = 0; s < 2; s++) begin
            applyStimulus(1'b0, 3'b000, 6'b000000, 1'b1, 1'b0, 1'b0);
            #1;
            checkOutput("abort_pre_step", 32'(out_step), 32'(s));
            nextCycle();
         end
         applyStimulus(1'b1, 3'b111, 6'b100000, 1'b1, (k == 0), (k == 1));
         #1;
         checkOutput("abort_step2", 32'(out_step), 32'd2);
         checkOutput("abort_oper", 32'(alu_operation), 32'hb);
         checkOutput("abort_in_ready", 32'(in_ready), 32'd0);
         nextCycle();
         applyStimulus(1'b0, 3'b000, 6'b000000, 1'b1, 1'b0, 1'b0);
         #1;
         checkIdle("abort_idle");
         checkOutput("abort_idle_rdy", 32'(in_ready), 32'd1);
         applyStimulus(1'b1, 3'b100, 6'b101010, 1'b1, 1'b0, 1'b0);
         nextCycle();
         applyStimulus(1'b0, 3'b000, 6'b000000, 1'b1, 1'b0, 1'b0);
         #1;
         checkOutput("addi_valid", 32'(out_valid), 32'd1);
         checkOutput("addi_oper", 32'(alu_operation), 32'h3);
         checkOutput("addi_step", 32'(out_step), 32'd0);
         checkOutput("addi_last", 32'(out_last), 32'd1);
         nextCycle();
         checkOutput("addi_done", 32'(out_valid), 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
